// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display-string arbiter.
package disp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MSG_W  = 64;
  localparam int BYTE_W = 8;

  // One-hot (up to 8 bits) to binary index; OR-encoding keeps it a flat mux.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/disp_string_arbiter_rr_pick.sv
// Winner picker for the display arbiter.
// Default: round-robin search upward from rr_ptr, wrapping modulo N_REQ.
// With DISP_ARB_FIXED_PRIO_EN defined: lowest set request bit wins, no pointer.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
`ifndef DISP_ARB_FIXED_PRIO_EN
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
`endif
  output logic [N_REQ-1:0]         win,
  output logic                     vld
);

  // Scan requesters in priority order and keep the first one found.
  always_comb begin
    int idx;
    win = '0;
    vld = 1'b0;
    idx = 0;
    for (int off = 0; off < N_REQ; off++) begin
`ifndef DISP_ARB_FIXED_PRIO_EN
      idx = int'(rr_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
`else
      idx = off;
`endif
      if (!vld && req[idx]) begin
        win[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_string_arbiter.sv
// Shares one 8-byte string-display engine between N_REQ requesters.
// Latches the winner's message, pulses disp_go, waits out the engine run,
// then acks the winner. Define DISP_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins) instead of round-robin.
//
// state | meaning
// IDLE  | no owner; pick a winner when any req is high
// START | disp_go pulse, message already latched
// RUN   | engine running; run_cnt counts up to DISP_CYCLES-1
// DONE  | ack pulse to owner; pointer advances; gnt clears on exit
module disp_string_arbiter
  import disp_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DISP_CYCLES = 16,
  parameter int MSG_W       = disp_arb_pkg::MSG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*MSG_W-1:0] msg_in,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   disp_go,
  output logic [MSG_W-1:0]       disp_msg
);

  localparam int CNT_W = $clog2(DISP_CYCLES) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   run_cnt;
  logic [N_REQ-1:0]   win;
  logic               win_vld;
  logic [MSG_W-1:0]   win_msg;

`ifndef DISP_ARB_FIXED_PRIO_EN
  localparam int PTR_W = $clog2(N_REQ);
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] own_idx;

  assign own_idx = PTR_W'(onehot_to_idx(8'(gnt)));
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
`ifndef DISP_ARB_FIXED_PRIO_EN
    .rr_ptr (rr_ptr),
`endif
    .win    (win),
    .vld    (win_vld)
  );

  // Select the winner's message slice for latching.
  always_comb begin
    win_msg = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) win_msg = msg_in[i*MSG_W +: MSG_W];
    end
  end

  // Next-state logic for the grant sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (run_cnt == CNT_W'(DISP_CYCLES - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant, message latch, run counter, ack and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      disp_msg <= '0;
      run_cnt  <= '0;
      ack      <= '0;
`ifndef DISP_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state <= state_nxt;
      ack   <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt      <= win;
            disp_msg <= win_msg;
          end
        end
        START: run_cnt <= CNT_W'(1);
        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (state_nxt == DONE) ack <= gnt;
        end
        DONE: begin
          gnt <= '0;
`ifndef DISP_ARB_FIXED_PRIO_EN
          rr_ptr <= (own_idx == PTR_W'(N_REQ - 1)) ? '0 : own_idx + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign disp_go = (state == START);
  assign busy    = (state != IDLE);

endmodule
